// File: rtl/munoc_rchannel_responder.sv
// ---------------------------------------------------------------------------
// munoc_rchannel_responder
//
// AXI read-data (R channel) responder for the slave-side network interface.
// Accepts one read request at a time, pops words from a local ready/request
// data source and emits a complete R burst (RID, RRESP, RLAST) through a
// single-entry output register that sustains one beat per cycle.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rstnn        synchronous active-low reset
//   ar_valid     read request valid
//   ar_ready     request accepted when ar_valid & ar_ready (high in IDLE)
//   ar_id        request ID, returned on r_id
//   ar_len       beats minus one
//   ar_size      log2 of bytes per beat
//   src_ready    data source holds a word
//   src_request  pop one word this cycle (only while src_ready)
//   src_data     source word, valid with src_ready
//   src_error    source word is erroneous, valid with src_ready
//   r_valid      R beat valid
//   r_ready      R beat accepted when r_valid & r_ready
//   r_id         latched ar_id
//   r_data       beat data, lanes beyond the beat size zeroed
//   r_resp       2'b00 OKAY, 2'b10 SLVERR
//   r_last       final beat of the burst
// ---------------------------------------------------------------------------
module munoc_rchannel_responder #(
    parameter int BW_TID  = 4,
    parameter int BW_DATA = 32,
    parameter int BW_LEN  = 8
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic                ar_valid,
    output logic                ar_ready,
    input  logic [BW_TID-1:0]   ar_id,
    input  logic [BW_LEN-1:0]   ar_len,
    input  logic [2:0]          ar_size,
    input  logic                src_ready,
    output logic                src_request,
    input  logic [BW_DATA-1:0]  src_data,
    input  logic                src_error,
    output logic                r_valid,
    input  logic                r_ready,
    output logic [BW_TID-1:0]   r_id,
    output logic [BW_DATA-1:0]  r_data,
    output logic [1:0]          r_resp,
    output logic                r_last
);

    localparam int NUM_BYTES = BW_DATA / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // One extra bit so that len=all-ones still terminates (counter reaches len+1).
    logic [BW_LEN:0]     r_cnt;
    logic [BW_LEN-1:0]   r_len;
    logic [2:0]          r_size;
    logic                r_size_bad;

    logic                w_ar_hs;
    logic                w_issue;
    logic                w_beats_left;
    logic                w_slot_free;
    logic                w_size_bad;
    logic [BW_DATA-1:0]  w_masked;

    // A beat wider than the data bus cannot be served: answer with SLVERR.
    assign w_size_bad   = (32'd8 << ar_size) > 32'(BW_DATA);
    assign w_ar_hs      = ar_valid & ar_ready;
    assign w_beats_left = (r_cnt <= {1'b0, r_len});
    // Output register can take a new beat if empty or being drained right now.
    assign w_slot_free  = ~r_valid | r_ready;

    // Keep only the byte lanes that belong to a beat of 2^size bytes.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            assign w_masked[gi*8 +: 8] = (32'(gi) < (32'd1 << r_size)) ?
                                         src_data[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ar_ready     = 1'b0;
        w_issue      = 1'b0;
        src_request  = 1'b0;
        case (r_state)
            IDLE: begin
                ar_ready = 1'b1;
                if (ar_valid) begin
                    w_state_next = BURST;
                end
            end
            BURST: begin
                if (w_beats_left && w_slot_free) begin
                    if (r_size_bad) begin
                        // Error beats are synthesized locally; the source is untouched.
                        w_issue = 1'b1;
                    end else if (src_ready) begin
                        w_issue     = 1'b1;
                        src_request = 1'b1;
                    end
                end
                if (r_valid && r_ready && r_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_size_bad <= 1'b0;
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_data     <= '0;
            r_resp     <= 2'b00;
            r_last     <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_id       <= ar_id;
                r_len      <= ar_len;
                r_size     <= ar_size;
                r_size_bad <= w_size_bad;
                r_cnt      <= '0;
            end
            if (w_issue) begin
                r_valid <= 1'b1;
                r_data  <= r_size_bad ? '0 : w_masked;
                r_resp  <= (r_size_bad || src_error) ? 2'b10 : 2'b00;
                r_last  <= (r_cnt == {1'b0, r_len});
                r_cnt   <= r_cnt + 1'b1;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_munoc_rchannel_responder.sv
// ---------------------------------------------------------------------------
// tb_munoc_rchannel_responder
//
// Self-checking bench for munoc_rchannel_responder (BW_TID=4, BW_DATA=32,
// BW_LEN=8). A table of directed bursts plus randomized bursts; expected beats
// are derived from the source words with the beat-size/error rules, and a
// per-cycle monitor checks beats, stalls, source pops and latencies.
// ---------------------------------------------------------------------------
module tb_munoc_rchannel_responder;

    logic        clk;
    logic        rstnn;
    logic        ar_valid;
    logic        ar_ready;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic        src_ready;
    logic        src_request;
    logic [31:0] src_data;
    logic        src_error;
    logic        r_valid;
    logic        r_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;

    munoc_rchannel_responder #(
        .BW_TID (4),
        .BW_DATA(32),
        .BW_LEN (8)
    ) dut (
        .clk        (clk),
        .rstnn      (rstnn),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_id      (ar_id),
        .ar_len     (ar_len),
        .ar_size    (ar_size),
        .src_ready  (src_ready),
        .src_request(src_request),
        .src_data   (src_data),
        .src_error  (src_error),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_id       (r_id),
        .r_data     (r_data),
        .r_resp     (r_resp),
        .r_last     (r_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct {
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [31:0] base;
        logic [15:0] err_mask;
        int          rr_mode;   // 0 always ready, 1 toggle, 2 random
        int          sr_mode;   // 0 source always ready, 1 random
        bit          timing;
        int          exp_pops;
        logic [31:0] exp_d0;
        logic [1:0]  exp_r0;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          beats, popped, first_rv, ar_cyc, last_cyc;
    bit          done, in_burst, prev_stall;
    beat_t       snap;
    logic [31:0] first_data;
    logic [1:0]  first_resp;
    logic [31:0] src_q[$];
    bit          err_q[$];
    beat_t       exp_q[$];
    vec_t        vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Beat data seen by the master: only the low 2^size bytes survive.
    function automatic logic [31:0] model_data(input logic [31:0] w, input int size);
        int nbytes;
        nbytes = 1 << size;
        if (nbytes >= 4) return w;
        return 32'(64'(w) % (64'd1 << (8 * nbytes)));
    endfunction

    // Inputs are already applied; sample at the falling edge, then move to
    // just after the next rising edge.
    task automatic cycle();
        beat_t act, e;
        @(negedge clk);
        cyc++;
        if (rstnn) begin
            check("src_req_without_ready", {63'b0, src_request & ~src_ready}, 64'd0);
            check("src_req_in_idle", {63'b0, src_request & ar_ready}, 64'd0);
            if (in_burst) check("ar_ready_busy", {63'b0, ar_ready}, 64'd0);
            act = '{id: r_id, data: r_data, resp: r_resp, last: r_last};
            if (prev_stall) check("stall_hold", {24'b0, r_valid, act}, {24'b0, 1'b1, snap});
            if (r_valid && first_rv < 0) first_rv = cyc;
            if (ar_valid && ar_ready) ar_cyc = cyc;
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_beat: got beat data %0h, required none", r_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d", beats), {25'b0, act}, {25'b0, e});
                    if (beats == 0) begin
                        first_data = r_data;
                        first_resp = r_resp;
                    end
                    beats++;
                    if (r_last) begin
                        done     = 1'b1;
                        in_burst = 1'b0;
                        last_cyc = cyc;
                    end
                end
            end
            if (src_request) begin
                popped++;
                if (src_q.size() > 0) begin
                    void'(src_q.pop_front());
                    void'(err_q.pop_front());
                end
            end
            prev_stall = r_valid & ~r_ready;
            snap       = act;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int rr_mode, input int sr_mode);
        case (rr_mode)
            0:       r_ready = 1'b1;
            1:       r_ready = cyc[0];
            default: r_ready = 1'($urandom_range(0, 1));
        endcase
        src_ready = (src_q.size() > 0) && (sr_mode == 0 || $urandom_range(0, 1) == 1);
        src_data  = (src_q.size() > 0) ? src_q[0] : $urandom;
        src_error = (src_q.size() > 0) ? err_q[0] : 1'($urandom_range(0, 1));
    endtask

    // src_q/err_q must already hold the words of this burst.
    task automatic run_burst(input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                             input int rr_mode, input int sr_mode, input int stop_after);
        bit bad;
        int budget;
        bad = (8 << size) > 32;
        exp_q.delete();
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back('{id: id,
                              data: bad ? 32'd0 : model_data(src_q[i], int'(size)),
                              resp: (bad || err_q[i]) ? 2'b10 : 2'b00,
                              last: (i == int'(len))});
        end
        beats = 0; popped = 0; first_rv = -1; ar_cyc = -1; last_cyc = -1;
        done = 1'b0; first_data = '0; first_resp = '0;
        ar_valid = 1'b1; ar_id = id; ar_len = len; ar_size = size;
        drive(rr_mode, sr_mode);
        cycle();
        check("ar_accept_cycle", 64'(ar_cyc), 64'(cyc));
        in_burst = 1'b1;
        ar_valid = 1'b0; ar_id = 4'($urandom); ar_len = 8'($urandom); ar_size = 3'($urandom);
        budget = 40 * (int'(len) + 2);
        for (int k = 0; k < budget && !done && !(stop_after > 0 && beats >= stop_after); k++) begin
            ar_valid = 1'($urandom_range(0, 1));
            drive(rr_mode, sr_mode);
            cycle();
        end
        ar_valid = 1'b0;
        if (stop_after == 0) begin
            check("burst_done", {63'b0, done}, 64'd1);
            check("src_pops", 64'(popped), bad ? 64'd0 : 64'(int'(len) + 1));
            check("ar_ready_after_last", {63'b0, ar_ready}, 64'd1);
            in_burst = 1'b0;
        end
    endtask

    initial begin
        rstnn = 1'b0; ar_valid = 1'b0; ar_id = '0; ar_len = '0; ar_size = '0;
        src_ready = 1'b0; src_data = '0; src_error = 1'b0; r_ready = 1'b0;
        in_burst = 1'b0; prev_stall = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rstnn = 1'b1;
        check("reset_values",
              {19'b0, ar_ready, r_valid, r_last, r_resp, r_data, r_id, src_request},
              {19'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 4'd0, 1'b0});

        //           id    len   size  base          err       rr sr tim pops d0            r0
        vecs[0] = '{4'd5, 8'd3, 3'd2, 32'h000000A0, 16'h0000, 0, 0, 1, 4, 32'h000000A0, 2'b00};
        vecs[1] = '{4'd1, 8'd0, 3'd0, 32'hDEADBEEF, 16'h0000, 0, 0, 1, 1, 32'h000000EF, 2'b00};
        vecs[2] = '{4'd2, 8'd2, 3'd3, 32'h00000055, 16'h0000, 0, 0, 1, 0, 32'h00000000, 2'b10};
        vecs[3] = '{4'd7, 8'd7, 3'd2, 32'h00000010, 16'h0000, 1, 1, 0, 8, 32'h00000010, 2'b00};
        vecs[4] = '{4'd3, 8'd3, 3'd2, 32'h000000B0, 16'h0004, 0, 0, 1, 4, 32'h000000B0, 2'b00};
        vecs[5] = '{4'd6, 8'd4, 3'd1, 32'h12345678, 16'h0001, 2, 1, 0, 5, 32'h00005678, 2'b10};

        for (int v = 0; v < 6; v++) begin
            src_q.delete(); err_q.delete();
            for (int i = 0; i <= int'(vecs[v].len); i++) begin
                src_q.push_back(vecs[v].base + 32'(i));
                err_q.push_back(vecs[v].err_mask[i]);
            end
            run_burst(vecs[v].id, vecs[v].len, vecs[v].size, vecs[v].rr_mode, vecs[v].sr_mode, 0);
            check($sformatf("vec%0d_first_data", v), 64'(first_data), 64'(vecs[v].exp_d0));
            check($sformatf("vec%0d_first_resp", v), 64'(first_resp), 64'(vecs[v].exp_r0));
            check($sformatf("vec%0d_pops", v), 64'(popped), 64'(vecs[v].exp_pops));
            if (vecs[v].timing) begin
                check($sformatf("vec%0d_first_rvalid_lat", v), 64'(first_rv - ar_cyc), 64'd2);
                check($sformatf("vec%0d_last_hs_lat", v), 64'(last_cyc - ar_cyc),
                      64'(int'(vecs[v].len) + 2));
            end
            $display("burst vec%0d id=%0d len=%0d size=%0d beats=%0d pops=%0d",
                     v, vecs[v].id, vecs[v].len, vecs[v].size, beats, popped);
        end

        // Reset in the middle of a 16-beat burst, then a fresh short burst.
        src_q.delete(); err_q.delete();
        for (int i = 0; i < 16; i++) begin
            src_q.push_back(32'hC0 + 32'(i));
            err_q.push_back(1'b0);
        end
        run_burst(4'd3, 8'd15, 3'd2, 0, 0, 2);
        in_burst = 1'b0;
        exp_q.delete();
        rstnn = 1'b0; r_ready = 1'b0; src_ready = 1'b0;
        cycle();
        rstnn = 1'b1;
        check("midreset_r_valid", {63'b0, r_valid}, 64'd0);
        check("midreset_ar_ready", {63'b0, ar_ready}, 64'd1);
        popped = 0;
        src_ready = 1'b1; src_data = src_q[0]; src_error = 1'b0; r_ready = 1'b1;
        cycle();
        check("midreset_no_pop", 64'(popped), 64'd0);
        src_q.delete(); err_q.delete();
        src_q.push_back(32'h11111111); err_q.push_back(1'b0);
        src_q.push_back(32'h22222222); err_q.push_back(1'b0);
        run_burst(4'd9, 8'd1, 3'd2, 0, 0, 0);
        check("post_reset_last_lat", 64'(last_cyc - ar_cyc), 64'd3);
        $display("burst after reset id=9 beats=%0d pops=%0d", beats, popped);

        // Randomized bursts, back-to-back.
        for (int b = 0; b < 20; b++) begin
            logic [7:0] len;
            logic [2:0] size;
            logic [3:0] id;
            len  = 8'($urandom_range(0, 15));
            size = 3'($urandom_range(0, 3));
            id   = 4'($urandom);
            src_q.delete(); err_q.delete();
            for (int i = 0; i <= int'(len); i++) begin
                src_q.push_back($urandom);
                err_q.push_back($urandom_range(0, 3) == 0);
            end
            run_burst(id, len, size, 2, 1, 0);
            $display("burst rand%0d id=%0d len=%0d size=%0d beats=%0d pops=%0d",
                     b, id, len, size, beats, popped);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
